axis_slave_rx: RTL

AXIS_SLAVE_RX -- requirements
Module: axis_slave_rx

---
 rtl/axis_pkg.sv | 12 +
 rtl/axis_sync_fifo.sv | 55 +++++
 rtl/axis_slave_rx.sv | 85 ++++++++
 3 files changed

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared constants and packet FSM encoding for the axis slave receiver
package axis_pkg;

    localparam int AXIS_DATA_W = 8;
    localparam int AXIS_DEST_W = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;

endpackage

// File: rtl/axis_sync_fifo.sv
// rtl/axis_sync_fifo.sv - single-clock FIFO with combinational head and occupancy count
module axis_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                     i_sclk,
    input  logic                     i_srst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_LVL  = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_PTR = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             push;
    logic             pop;

    // Guards here keep the FIFO safe even if a caller forgets to qualify requests.
    assign push = i_wr_en && (level != FULL_LVL);
    assign pop  = i_rd_en && (level != '0);

    always_ff @(posedge i_sclk) begin
        if (i_srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ONE_PTR;
            if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
            case ({push, pop})
                2'b10:   level <= level + ONE_LVL;
                2'b01:   level <= level - ONE_LVL;
                default: level <= level;
            endcase
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge i_sclk) begin
        if (push) mem[wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = mem[rd_ptr];
    assign o_level   = level;

endmodule

// File: rtl/axis_slave_rx.sv
// rtl/axis_slave_rx.sv - tdest-filtered stream sink into a local FIFO; AXIS_SLAVE_RX_STATS_EN adds beat/packet counters
module axis_slave_rx
    import axis_pkg::*;
#(
    parameter int                  DATA_W  = AXIS_DATA_W,
    parameter int                  DEST_W  = AXIS_DEST_W,
    parameter logic [DEST_W-1:0]   MY_DEST = 5'b00010,
    parameter int                  DEPTH   = 8
) (
    input  logic                     i_sclk,
    input  logic                     i_srst,
    input  logic                     i_s_tvalid,
    input  logic [DEST_W-1:0]        i_s_tdest,
    input  logic [DATA_W-1:0]        i_s_tdata,
    input  logic                     i_s_tlast,
    output logic                     o_m_s_tready,
    input  logic                     i_rd_en,
    output logic                     o_rd_valid,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_rd_last,
    output logic                     o_pkt_done,
`ifdef AXIS_SLAVE_RX_STATS_EN
    output logic [15:0]              o_beat_cnt,
    output logic [15:0]              o_pkt_cnt,
`endif
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [AW:0]   level;
    logic [DATA_W:0] head;
    logic          accept;
    pkt_state_t    pkt_state;

    // Ready uses the pre-edge level, so a full FIFO never accepts even if a pop is pending.
    assign o_m_s_tready = !i_srst && (level != FULL_LVL) && (i_s_tdest == MY_DEST);
    assign accept       = i_s_tvalid && o_m_s_tready;

    axis_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_sclk    (i_sclk),
        .i_srst    (i_srst),
        .i_wr_en   (accept),
        .i_wr_data ({i_s_tlast, i_s_tdata}),
        .i_rd_en   (i_rd_en),
        .o_rd_data (head),
        .o_level   (level)
    );

    assign o_rd_valid = (level != '0);
    assign o_rd_data  = head[DATA_W-1:0];
    assign o_rd_last  = head[DATA_W];
    assign o_level    = level;

    always_ff @(posedge i_sclk) begin
        if (i_srst) begin
            pkt_state  <= IDLE;
            o_pkt_done <= 1'b0;
        end else begin
            o_pkt_done <= accept && i_s_tlast;
            case (pkt_state)
                IDLE:    if (accept && !i_s_tlast) pkt_state <= IN_PKT;
                IN_PKT:  if (accept && i_s_tlast)  pkt_state <= IDLE;
                default: pkt_state <= IDLE;
            endcase
        end
    end

`ifdef AXIS_SLAVE_RX_STATS_EN
    always_ff @(posedge i_sclk) begin
        if (i_srst) begin
            o_beat_cnt <= '0;
            o_pkt_cnt  <= '0;
        end else if (accept) begin
            o_beat_cnt <= o_beat_cnt + 16'd1;
            if (i_s_tlast) o_pkt_cnt <= o_pkt_cnt + 16'd1;
        end
    end
`endif

endmodule
